tick_scheduler: RTL
===================

// Module: tick_scheduler
// PURPOSE
//  Multi-channel rate generator replacing the hard-coded 60 Hz / instruction-rate counters in top.
//  Each channel has a runtime-programmable divisor, emits one-cycle tick pulses, and banks unconsumed ticks as credits.
//  The CPU uses credits to catch up on missed instruction slots; a turbo input forces selected channels to run every cycle.
//  Sits between CLK and cpu/screen_bridge: ch0 = 60 Hz timers/refresh, ch1 = instruction pacing.
// PARAMETERS
//  CLK_FREQ     16_000_000          input clock frequency, Hz
//  NUM_CH       2                   number of channels (1..8)
//  DIV_W        20                  divisor / counter width
//  CREDIT_W     4                   per-channel credit counter width
//  DIV0_DEFAULT CLK_FREQ/60         reset divisor, channel 0
//  DIVN_DEFAULT CLK_FREQ/500        reset divisor, channels 1..NUM_CH-1
//  TURBO_MASK   {NUM_CH{1'b0}}|2'b10 channels affected by turbo (bit per channel)
// PORTS
//  clk      in   1                  system clock
//  rst_n    in   1                  asynchronous active-low reset
//  turbo_n  in   1                  async turbo request, active low (pullup pin), 2-flop synchronised
//  pause    in   1                  freeze all channel counters
//  resync   in   1                  restart every channel phase together
//  cfg_we   in   1                  divisor write strobe
//  cfg_ch   in   clog2(NUM_CH)      channel selected by cfg_we
//  cfg_div  in   DIV_W              new divisor value
//  take     in   NUM_CH             consumer takes one credit per channel
//  ovf_clr  in   NUM_CH             clear sticky overflow per channel
//  tick     out  NUM_CH             one-cycle registered tick pulse
//  avail    out  NUM_CH             credit available (or turbo active) per channel
//  credit   out  NUM_CH*CREDIT_W    packed credit counts, ch0 in LSBs
//  ovf      out  NUM_CH             sticky: tick arrived while credit saturated
// BEHAVIOUR
//  Reset (async, rst_n=0): tick=0, credit=0, ovf=0, avail=0, divisors=defaults, counters=div-1,
//    turbo sync flops=1 (turbo off).
//  Period: counter counts down div-1..0; at 0 it reloads div-1 and tick is asserted on the NEXT cycle (1-cycle latency).
//    Tick period is exactly div cycles; div=0 or 1 -> tick every cycle.
//  pause=1: counters hold, no new ticks; credits and take still operate. Release resumes from the held count.
//  resync=1: all counters load div-1 that cycle, no tick generated; resync dominates pause.
//  cfg_we: loads divisor[cfg_ch]=cfg_div and counter[cfg_ch]=cfg_div-1 (0 if cfg_div=0); no tick from that channel that cycle.
//    cfg_ch >= NUM_CH is ignored.
//  Turbo: turbo_act = synced turbo_n==0, 2-cycle sync latency. For channels in TURBO_MASK with turbo_act:
//    tick=1 every cycle, avail=1, credit frozen (take ignored). Unmasked channels unaffected.
//  Credit (per channel, non-turbo): tick&~take -> +1; take&~tick -> -1 if credit>0, else no change (underflow ignored);
//    tick&take -> unchanged.
//  Credit saturation: at all-ones credit a tick without take leaves credit at max and sets ovf. ovf_clr clears ovf;
//    a simultaneous set wins over clear.
//  avail = (credit!=0) | turbo-masked active; combinational from registered state, no input path.
//  Counter arithmetic is unsigned DIV_W; no wrap other than reload.
//  rst_n asserted mid-period discards the phase and credits immediately; first tick after release is div cycles later.
// TESTING
//  1 DIV0=4, DIV1=6, 30 cycles after reset, no take -> tick[0] at cycles 4,8,..,28; tick[1] at 6,12,..,30; credits 7 and 5.
//  2 Credit 3 on ch1, take pulsed 5 cycles with no tick -> credit 3,2,1,0,0; avail drops when credit reaches 0; ovf stays 0.
//  3 CREDIT_W=2, 5 ticks no take -> credit saturates at 3, ovf=1 after 4th tick; ovf_clr with tick -> ovf stays 1;
//    ovf_clr alone -> ovf 0.
//  4 turbo_n low -> 2 cycles later tick[1]=1 every cycle, avail[1]=1, credit[1] frozen; tick[0] period unchanged;
//    turbo_n high -> normal after 2 cycles.
//  5 cfg_we ch0 div=10 mid-period -> no tick that cycle, next tick exactly 10 cycles later;
//    cfg_ch=3 with NUM_CH=2 -> no state change.
//  6 pause 7 cycles mid-period then release -> tick delayed by exactly 7;
//    resync and pause together -> all counters reload; rst_n pulse mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel programmable tick generator with credit banking
module tick_scheduler #(
  parameter int unsigned       CLK_FREQ     = 16_000_000,
  parameter int unsigned       NUM_CH       = 2,
  parameter int unsigned       DIV_W        = 20,
  parameter int unsigned       CREDIT_W     = 4,
  parameter int unsigned       DIV0_DEFAULT = CLK_FREQ / 60,
  parameter int unsigned       DIVN_DEFAULT = CLK_FREQ / 500,
  parameter logic [NUM_CH-1:0] TURBO_MASK   = NUM_CH'(2'b10),
  localparam int unsigned      CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         turbo_n,
  input  logic                         pause,
  input  logic                         resync,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [NUM_CH-1:0]            take,
  input  logic [NUM_CH-1:0]            ovf_clr,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0]            avail,
  output logic [NUM_CH*CREDIT_W-1:0]   credit,
  output logic [NUM_CH-1:0]            ovf
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  // Reload value for a divisor; 0 and 1 both mean "tick every cycle".
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  function automatic logic [DIV_W-1:0] default_div(input int c);
    return (c == 0) ? DIV_W'(DIV0_DEFAULT) : DIV_W'(DIVN_DEFAULT);
  endfunction

  logic [1:0]          turbo_sync_q;
  logic                turbo_act;
  logic [NUM_CH-1:0]   turbo_vec;

  logic [DIV_W-1:0]    div_q [NUM_CH];
  logic [DIV_W-1:0]    div_d [NUM_CH];
  logic [DIV_W-1:0]    cnt_q [NUM_CH];
  logic [DIV_W-1:0]    cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   fire_d;
  logic [NUM_CH-1:0]   tick_q;

  logic [CREDIT_W-1:0] credit_q [NUM_CH];
  logic [CREDIT_W-1:0] credit_d [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q;
  logic [NUM_CH-1:0]   ovf_d;
  logic [NUM_CH-1:0]   ovf_set;

  // Two-flop synchroniser for the pin-level turbo request; resets to "off".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) turbo_sync_q <= 2'b11;
    else        turbo_sync_q <= {turbo_sync_q[0], turbo_n};
  end

  assign turbo_act = ~turbo_sync_q[1];
  assign turbo_vec = TURBO_MASK & {NUM_CH{turbo_act}};

  // Per-channel phase counter: config write beats resync beats pause beats normal countdown.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    fire_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_we && (int'(cfg_ch) == c)) begin
        div_d[c] = cfg_div;
        cnt_d[c] = reload_val(cfg_div);
      end else if (resync) begin
        cnt_d[c] = reload_val(div_q[c]);
      end else if (!pause) begin
        if (cnt_q[c] == '0) begin
          cnt_d[c]  = reload_val(div_q[c]);
          fire_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] - DIV_W'(1);
        end
      end
    end
  end

  // Credit banking against the visible tick; turbo-forced channels keep their credit frozen.
  always_comb begin
    credit_d = credit_q;
    ovf_set  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!turbo_vec[c]) begin
        if (tick_q[c] && !take[c]) begin
          if (credit_q[c] == CREDIT_MAX) ovf_set[c] = 1'b1;
          else                           credit_d[c] = credit_q[c] + CREDIT_W'(1);
        end else if (take[c] && !tick_q[c] && (credit_q[c] != '0)) begin
          credit_d[c] = credit_q[c] - CREDIT_W'(1);
        end
      end
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  // State registers; reset discards phase and credits immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c]    <= default_div(c);
        cnt_q[c]    <= reload_val(default_div(c));
        credit_q[c] <= '0;
      end
      tick_q <= '0;
      ovf_q  <= '0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      tick_q   <= fire_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs are derived from registered state only.
  always_comb begin
    credit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      credit[c*CREDIT_W +: CREDIT_W] = credit_q[c];
      avail[c] = (credit_q[c] != '0) | turbo_vec[c];
    end
    tick = tick_q | turbo_vec;
    ovf  = ovf_q;
  end

endmodule
